// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher block.
// Holds the stretcher state encodings and the slow-clock (~24.4 kHz) timing
// constants that the debouncers also use.
package pulse_stretcher_pkg;

  typedef logic [1:0] state_t;

  // Fixed encodings kept bit-compatible with the original design; 2'b11 is
  // illegal and recovers to ST_IDLE.
  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_HOLD = 2'b01;
  localparam state_t ST_GAP  = 2'b10;

  // Slow-clock durations: ~0.25 s and ~0.1 s at 24.4 kHz.
  localparam int unsigned SLOW_CYCLES_250MS = 6100;
  localparam int unsigned SLOW_CYCLES_100MS = 2440;

  function automatic logic is_active(input state_t s);
    return (s == ST_HOLD) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/pulse_stretcher_interval_timer.sv
// Interval timer for the pulse stretcher.
// Counts enabled cycles from zero and flags the last cycle of an interval
// whose length is supplied at run time.
// Ports:
//   clk     - clock
//   reset   - synchronous active-high reset, clears the count
//   clear   - synchronous clear, takes priority over enable
//   enable  - advance the count by one this cycle
//   length  - interval length in cycles (>= 1)
//   done    - high on the last cycle of the interval (count == length-1)
module interval_timer #(
  parameter int unsigned CNT_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] length,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Exact equality; the caller clears the counter on done, so it never wraps.
  assign done = enable && (count == (length - 1'b1));

endmodule

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle event pulses into human-visible
// high intervals (HOLD_CYCLES long), each followed by a low gap
// (GAP_CYCLES long). Events arriving while busy are queued so that
// N events always yield N blinks.
// Ports:
//   CLK       - slow-domain clock
//   RESET     - synchronous active-high reset
//   Pulse_in  - event request, every high cycle counts as one event
//   Clear_ovf - clears the sticky Overflow flag
//   Stretched - stretched output (high only while holding)
//   Busy      - high whenever not idle
//   Pending   - number of queued events not yet started
//   Overflow  - sticky, set when an event is dropped on a full queue
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = SLOW_CYCLES_250MS,
  parameter int unsigned GAP_CYCLES  = SLOW_CYCLES_100MS,
  parameter int unsigned MAX_PENDING = 7,
  parameter int unsigned CNT_W       = 13,
  parameter int unsigned PEND_W      = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Pulse_in,
  input  logic              Clear_ovf,
  output logic              Stretched,
  output logic              Busy,
  output logic [PEND_W-1:0] Pending,
  output logic              Overflow
);

  localparam logic [CNT_W-1:0]  HOLD_LEN = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]  GAP_LEN  = CNT_W'(GAP_CYCLES);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  state_t            state;
  state_t            state_nxt;
  logic [PEND_W-1:0] pend_nxt;
  logic              ovf_set;
  logic              tmr_clear;
  logic              tmr_en;
  logic              tmr_done;
  logic [CNT_W-1:0]  tmr_len;

  interval_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (CLK),
    .reset  (RESET),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .length (tmr_len),
    .done   (tmr_done)
  );

  always_comb begin
    state_nxt = state;
    pend_nxt  = Pending;
    ovf_set   = 1'b0;
    tmr_clear = 1'b0;
    tmr_en    = is_active(state);
    tmr_len   = (state == ST_HOLD) ? HOLD_LEN : GAP_LEN;

    case (state)
      ST_IDLE: begin
        tmr_clear = 1'b1;
        if (Pulse_in) begin
          state_nxt = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (tmr_done) begin
          state_nxt = ST_GAP;
          tmr_clear = 1'b1;
        end
        if (Pulse_in) begin
          if (Pending == PEND_MAX) begin
            ovf_set = 1'b1;
          end else begin
            pend_nxt = Pending + 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (tmr_done) begin
          tmr_clear = 1'b1;
          if (Pending != '0) begin
            // Dequeue; a same-cycle arrival replaces the dequeued slot.
            state_nxt = ST_HOLD;
            if (!Pulse_in) begin
              pend_nxt = Pending - 1'b1;
            end
          end else if (Pulse_in) begin
            state_nxt = ST_HOLD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (Pulse_in) begin
          if (Pending == PEND_MAX) begin
            ovf_set = 1'b1;
          end else begin
            pend_nxt = Pending + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        tmr_clear = 1'b1;
        pend_nxt  = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      Pending   <= '0;
      Overflow  <= 1'b0;
      Stretched <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      Pending   <= pend_nxt;
      Overflow  <= ovf_set | (Overflow & ~Clear_ovf);
      Stretched <= (state_nxt == ST_HOLD);
      Busy      <= (state_nxt != ST_IDLE);
    end
  end

endmodule
